// File: rtl/image_overlay_writer.sv
// Avalon-MM loaded 8x8 luma overlay, double-buffered, replayed onto the VGA pixel stream.
// Commits are armed by the CPU and take effect at the next frame start so the display never tears.
module image_overlay_writer #(
  parameter int unsigned ORIGIN_X = 208,
  parameter int unsigned ORIGIN_Y = 128,
  parameter int unsigned IMG_W    = 8,
  parameter int unsigned IMG_H    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        pix_valid,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  output logic        ovl_valid,
  output logic        ovl_hit,
  output logic [7:0]  ovl_y
);

  localparam int unsigned DEPTH = IMG_W * IMG_H;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   ptr;
  logic            front;
  logic            enable;
  logic            pending_c;
  logic            swap_c;
  logic [7:0]      mem [2*DEPTH];

  logic            ptr_wr_c, data_wr_c, ctrl_wr_c, frame_start_c;
  logic            inside_c, hit_c;
  logic [10:0]     dx_c, dy_c, idx11_c;
  logic [AW-1:0]   idx_c;
  logic            unused;

  assign unused        = ^writedata[31:8];
  assign ptr_wr_c      = wr_en && (addr == 2'd0);
  assign data_wr_c     = wr_en && (addr == 2'd1);
  assign ctrl_wr_c     = wr_en && (addr == 2'd2);
  assign frame_start_c = pix_valid && (pix_x == 11'd0) && (pix_y == 11'd0);

  // Commit FSM: state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Commit FSM: next state; a frame start colliding with a pixel write defers the swap
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_wr_c && writedata[1]) state_nxt = ARMED;
      ARMED:   if (frame_start_c && !data_wr_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Commit FSM: outputs
  always_comb begin
    pending_c = 1'b0;
    swap_c    = 1'b0;
    if (state == ARMED) begin
      pending_c = 1'b1;
      swap_c    = frame_start_c && !data_wr_c;
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr    <= '0;
      front  <= 1'b0;
      enable <= 1'b0;
    end else begin
      if (ptr_wr_c)       ptr <= writedata[AW-1:0];
      else if (data_wr_c) ptr <= ptr + AW'(1);
      if (ctrl_wr_c)      enable <= writedata[0];
      if (swap_c)         front <= ~front;
    end
  end

  // Pixel storage: the CPU only ever writes the back bank; contents survive reset
  always_ff @(posedge clk) begin
    if (data_wr_c) mem[{~front, ptr}] <= writedata[7:0];
  end

  always_comb begin
    readdata = 32'd0;
    if (rd_en) begin
      case (addr)
        2'd0: readdata = {26'd0, ptr};
        2'd1: readdata = {24'd0, mem[{~front, ptr}]};
        2'd2: readdata = {29'd0, pending_c, front, enable};
        default: readdata = {8'd1, 8'(IMG_W), 8'(IMG_H), 8'd0};
      endcase
    end
  end

  // Window test and index, only meaningful when inside
  always_comb begin
    inside_c = (pix_x >= 11'(ORIGIN_X)) && (pix_x < 11'(ORIGIN_X + IMG_W)) &&
               (pix_y >= 11'(ORIGIN_Y)) && (pix_y < 11'(ORIGIN_Y + IMG_H));
    dx_c     = pix_x - 11'(ORIGIN_X);
    dy_c     = pix_y - 11'(ORIGIN_Y);
    idx11_c  = 11'(dy_c * 11'(IMG_W)) + dx_c;
    idx_c    = inside_c ? idx11_c[AW-1:0] : '0;
    hit_c    = pix_valid && enable && inside_c;
  end

  // Overlay output; at a swap edge this still reads the pre-swap front bank
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovl_valid <= 1'b0;
      ovl_hit   <= 1'b0;
      ovl_y     <= 8'd0;
    end else begin
      ovl_valid <= pix_valid;
      ovl_hit   <= hit_c;
      ovl_y     <= hit_c ? mem[{front, idx_c}] : 8'd0;
    end
  end

endmodule

// File: tb/tb_image_overlay_writer.sv
// Directed bench for image_overlay_writer: register map, overlay replay and commit/swap behaviour.
module tb_image_overlay_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  addr;
  logic        rd_en, wr_en;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        pix_valid;
  logic [10:0] pix_x, pix_y;
  logic        ovl_valid, ovl_hit;
  logic [7:0]  ovl_y;

  int errors = 0;
  int checks = 0;

  image_overlay_writer dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .writedata(writedata), .readdata(readdata), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .ovl_valid(ovl_valid), .ovl_hit(ovl_hit),
    .ovl_y(ovl_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; writedata = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a; rd_en = 1'b1;
    #1;
    d = readdata;
    rd_en = 1'b0;
  endtask

  task automatic pix(input int x, input int y);
    pix_valid = 1'b1; pix_x = 11'(x); pix_y = 11'(y);
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic chk_pix(input string tag, input int x, input int y,
                         input logic hit, input logic [7:0] y_exp);
    pix(x, y);
    check({tag, "_valid"}, 32'(ovl_valid), 32'd1);
    check({tag, "_hit"},   32'(ovl_hit),   32'(hit));
    check({tag, "_y"},     32'(ovl_y),     32'(y_exp));
  endtask

  initial begin
    logic [31:0] d;
    reset_n = 1'b0; addr = 2'd0; rd_en = 1'b0; wr_en = 1'b0; writedata = 32'd0;
    pix_valid = 1'b0; pix_x = 11'd0; pix_y = 11'd0;
    tick(); tick();
    reset_n = 1'b1;

    // Reset state
    check("rst_ovl_valid", 32'(ovl_valid), 32'd0);
    check("rst_ovl_hit", 32'(ovl_hit), 32'd0);
    chk_rd("rst_ctrl", 2'd2, 32'd0);
    chk_rd("id_word", 2'd3, 32'h01080800);
    addr = 2'd3; #1; check("rd_idle_zero", readdata, 32'd0);
    chk_pix("disabled", 208, 128, 1'b0, 8'd0);

    // Load back bank (bank 1) with k+16
    wr(2'd0, 32'd0);
    for (int k = 0; k < 64; k++) wr(2'd1, 32'(k + 16));
    chk_rd("ptr_wrap", 2'd0, 32'd0);
    chk_rd("back_rd", 2'd1, 32'd16);
    chk_rd("back_rd_noinc", 2'd0, 32'd0);
    wr(2'd2, 32'h3);
    chk_rd("armed", 2'd2, 32'h5);
    pix(0, 0);
    chk_rd("swapped", 2'd2, 32'h3);
    chk_pix("inner", 211, 129, 1'b1, 8'd27);
    chk_pix("corner_tl", 208, 128, 1'b1, 8'd16);
    chk_pix("corner_br", 215, 135, 1'b1, 8'd79);
    chk_pix("left", 207, 128, 1'b0, 8'd0);
    chk_pix("right", 216, 128, 1'b0, 8'd0);
    chk_pix("above", 208, 127, 1'b0, 8'd0);
    chk_pix("below", 208, 136, 1'b0, 8'd0);
    pix_valid = 1'b0; tick();
    check("idle_valid", 32'(ovl_valid), 32'd0);

    // Double commit -> one swap
    wr(2'd2, 32'h3);
    wr(2'd2, 32'h3);
    chk_rd("dbl_armed", 2'd2, 32'h7);
    pix(0, 0);
    chk_rd("dbl_swap", 2'd2, 32'h1);
    pix(0, 0);
    chk_rd("dbl_noswap", 2'd2, 32'h1);

    // Frame start colliding with a pixel write defers the swap
    wr(2'd0, 32'd5);
    wr(2'd2, 32'h3);
    chk_rd("def_armed", 2'd2, 32'h5);
    addr = 2'd1; writedata = 32'hAA; wr_en = 1'b1;
    pix_valid = 1'b1; pix_x = 11'd0; pix_y = 11'd0;
    tick();
    wr_en = 1'b0; pix_valid = 1'b0;
    chk_rd("def_held", 2'd2, 32'h5);
    chk_rd("def_ptr", 2'd0, 32'd6);
    pix(0, 0);
    chk_rd("def_swap", 2'd2, 32'h3);
    chk_pix("def_data", 213, 128, 1'b1, 8'hAA);
    chk_pix("def_old", 214, 128, 1'b1, 8'd22);

    // Reset while armed discards the commit
    wr(2'd2, 32'h3);
    chk_rd("rst_armed", 2'd2, 32'h7);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk_rd("rst_clear", 2'd2, 32'd0);
    chk_rd("rst_ptr", 2'd0, 32'd0);
    pix(0, 0);
    chk_rd("rst_noswap", 2'd2, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
